// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Two-requester write arbiter in front of a register file. Each cycle at
// most one request is granted. A round-robin pointer breaks ties, and the
// granted write is presented to the register file one cycle later as a
// registered strobe, a one-hot select and a data word. A write to a
// write-protected register still completes its handshake. It is then
// dropped and reported with a one-cycle ProtectError pulse.
//
// Ports
//   Clock               in   rising-edge clock
//   ResetN              in   asynchronous active-low reset
//   AValid/BValid       in   write request from requester A / B
//   AAddress/BAddress   in   register index 0..NUM_REGS-1
//   AData/BData         in   write value
//   AReady/BReady       out  request accepted this cycle (combinational)
//   Stall               in   register file cannot take a write this cycle
//   WriteProtect        in   per-register protect mask, bit (index+1)
//   WriteEnable         out  registered write strobe
//   WriteAddressDecoded out  registered one-hot select, bit (index+1)
//   WriteValue          out  registered write data, holds when idle
//   ProtectError        out  one-cycle pulse: accepted write was dropped
//   ConflictCount       out  saturating count of cycles with both valid
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int NUM_REGS   = 32,
  parameter int DATA_WIDTH = 16
) (
  input  logic                        Clock,
  input  logic                        ResetN,
  input  logic                        AValid,
  input  logic [$clog2(NUM_REGS)-1:0] AAddress,
  input  logic [DATA_WIDTH-1:0]       AData,
  output logic                        AReady,
  input  logic                        BValid,
  input  logic [$clog2(NUM_REGS)-1:0] BAddress,
  input  logic [DATA_WIDTH-1:0]       BData,
  output logic                        BReady,
  input  logic                        Stall,
  input  logic [NUM_REGS:1]           WriteProtect,
  output logic                        WriteEnable,
  output logic [NUM_REGS:1]           WriteAddressDecoded,
  output logic [DATA_WIDTH:1]         WriteValue,
  output logic                        ProtectError,
  output logic [7:0]                  ConflictCount
);

  localparam int ADDR_W = $clog2(NUM_REGS);

  // Round-robin pointer: 0 favours A, 1 favours B on a tie.
  logic                  priority_reg;

  logic                  write_enable_reg;
  logic [NUM_REGS:1]     write_decoded_reg;
  logic [DATA_WIDTH:1]   write_value_reg;
  logic                  protect_error_reg;
  logic [7:0]            conflict_count_reg;

  logic                  grant_a;
  logic                  grant_b;
  logic                  grant_any;
  logic [ADDR_W-1:0]     sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NUM_REGS:1]     decode_next;
  logic                  sel_protected;
  logic                  both_valid;

  // -------------------------------------------------------------------------
  // Grant logic.
  // A requester wins if it is valid and either has no competitor or holds
  // priority. Gating with ResetN keeps both Ready outputs low while the
  // block is in reset, even though the grant path is combinational.
  // -------------------------------------------------------------------------
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (ResetN && !Stall) begin
      grant_a = AValid && (!BValid || !priority_reg);
      grant_b = BValid && (!AValid ||  priority_reg);
    end
  end

  assign grant_any  = grant_a | grant_b;
  assign both_valid = AValid & BValid;

  // Select the granted request. When B is not granted, A's fields pass
  // through. They are only consumed when grant_any is set.
  assign sel_addr = grant_b ? BAddress : AAddress;
  assign sel_data = grant_b ? BData    : AData;

  // -------------------------------------------------------------------------
  // One-hot decode of the selected index onto the 1-based select vector.
  // The same vector picks out the protect bit for that register, so the
  // protect check uses exactly the decode the register file would see.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 1; gi <= NUM_REGS; gi++) begin : g_decode
      assign decode_next[gi] = (sel_addr == ADDR_W'(gi - 1));
    end
  endgenerate

  assign sel_protected = |(decode_next & WriteProtect);

  // -------------------------------------------------------------------------
  // Priority pointer and write-port registers.
  // Every output strobe is rebuilt each cycle, so each lasts exactly one
  // cycle. WriteValue only loads on an unprotected grant and otherwise
  // keeps the last value written. An asynchronous reset therefore discards
  // any write accepted just before it.
  // -------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      priority_reg      <= 1'b0;
      write_enable_reg  <= 1'b0;
      write_decoded_reg <= '0;
      write_value_reg   <= '0;
      protect_error_reg <= 1'b0;
    end else begin
      write_enable_reg  <= 1'b0;
      write_decoded_reg <= '0;
      protect_error_reg <= 1'b0;
      if (grant_any) begin
        // Hand priority to the requester that was not served.
        priority_reg <= grant_a;
        if (sel_protected) begin
          protect_error_reg <= 1'b1;
        end else begin
          write_enable_reg  <= 1'b1;
          write_decoded_reg <= decode_next;
          write_value_reg   <= sel_data;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Contention counter.
  // Any edge where both requesters are valid counts, whether or not a grant
  // happens. The counter saturates and does not wrap.
  // -------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      conflict_count_reg <= '0;
    end else if (both_valid && (conflict_count_reg != 8'hFF)) begin
      conflict_count_reg <= conflict_count_reg + 8'd1;
    end
  end

  assign AReady              = grant_a;
  assign BReady              = grant_b;
  assign WriteEnable         = write_enable_reg;
  assign WriteAddressDecoded = write_decoded_reg;
  assign WriteValue          = write_value_reg;
  assign ProtectError        = protect_error_reg;
  assign ConflictCount       = conflict_count_reg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter. Inputs change 1 ns after a
// rising edge. The Ready outputs are checked 1 ns after that, and the
// registered outputs are checked 1 ns after the following rising edge.
module tb_regfile_write_arbiter;

  logic        Clock = 1'b0;
  logic        ResetN;
  logic        AValid;
  logic [4:0]  AAddress;
  logic [15:0] AData;
  logic        AReady;
  logic        BValid;
  logic [4:0]  BAddress;
  logic [15:0] BData;
  logic        BReady;
  logic        Stall;
  logic [32:1] WriteProtect;
  logic        WriteEnable;
  logic [32:1] WriteAddressDecoded;
  logic [16:1] WriteValue;
  logic        ProtectError;
  logic [7:0]  ConflictCount;

  int pass_count = 0;
  int total_count = 0;

  regfile_write_arbiter #(.NUM_REGS(32), .DATA_WIDTH(16)) dut (
    .Clock(Clock), .ResetN(ResetN),
    .AValid(AValid), .AAddress(AAddress), .AData(AData), .AReady(AReady),
    .BValid(BValid), .BAddress(BAddress), .BData(BData), .BReady(BReady),
    .Stall(Stall), .WriteProtect(WriteProtect),
    .WriteEnable(WriteEnable), .WriteAddressDecoded(WriteAddressDecoded),
    .WriteValue(WriteValue), .ProtectError(ProtectError),
    .ConflictCount(ConflictCount)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_count++;
    assert (obs === exp) pass_count++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [15:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [15:0] bd,
                       input logic st);
    AValid = av; AAddress = aa; AData = ad;
    BValid = bv; BAddress = ba; BData = bd;
    Stall = st;
    #1;
  endtask

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic check_ready(input string tag, input logic ea, input logic eb);
    check({tag, " AReady"}, 32'(AReady), 32'(ea));
    check({tag, " BReady"}, 32'(BReady), 32'(eb));
  endtask

  task automatic check_out(input string tag, input logic we, input logic [31:0] dec,
                           input logic [15:0] val, input logic pe);
    check({tag, " WriteEnable"}, 32'(WriteEnable), 32'(we));
    check({tag, " WriteAddressDecoded"}, WriteAddressDecoded, dec);
    check({tag, " WriteValue"}, 32'(WriteValue), 32'(val));
    check({tag, " ProtectError"}, 32'(ProtectError), 32'(pe));
    $display("step %s: WE=%0b dec=%h val=%h pe=%0b cc=%0d", tag, WriteEnable,
             WriteAddressDecoded, WriteValue, ProtectError, ConflictCount);
  endtask

  task automatic apply_reset;
    ResetN = 1'b0;
    drive(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0, 1'b0);
    @(negedge Clock);
    @(negedge Clock);
    ResetN = 1'b1;
    tick();
  endtask

  initial begin
    WriteProtect = '0;
    ResetN = 1'b0;
    // Reset state, with A requesting to show Ready stays low in reset.
    drive(1'b1, 5'd4, 16'hDEAD, 1'b1, 5'd9, 16'hBEEF, 1'b0);
    tick();
    check_ready("reset", 1'b0, 1'b0);
    check_out("reset", 1'b0, 32'h0, 16'h0, 1'b0);
    check("reset ConflictCount", 32'(ConflictCount), 32'd0);
    apply_reset();

    // Single write followed back-to-back by a write to the top register.
    drive(1'b1, 5'd5, 16'h1234, 1'b0, 5'd0, 16'h0, 1'b0);
    check_ready("single", 1'b1, 1'b0);
    tick();
    check_out("single", 1'b1, 32'h0000_0020, 16'h1234, 1'b0);
    drive(1'b1, 5'd31, 16'hABCD, 1'b0, 5'd0, 16'h0, 1'b0);
    check_ready("b2b", 1'b1, 1'b0);
    tick();
    check_out("b2b", 1'b1, 32'h8000_0000, 16'hABCD, 1'b0);
    drive(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0, 1'b0);
    tick();
    check_out("idle", 1'b0, 32'h0, 16'hABCD, 1'b0);

    // Fairness: A,B,A,B after reset.
    apply_reset();
    drive(1'b1, 5'd1, 16'hAAAA, 1'b1, 5'd2, 16'hBBBB, 1'b0);
    check_ready("fair1", 1'b1, 1'b0);
    tick();
    check_out("fair1", 1'b1, 32'h2, 16'hAAAA, 1'b0);
    check_ready("fair2", 1'b0, 1'b1);
    tick();
    check_out("fair2", 1'b1, 32'h4, 16'hBBBB, 1'b0);
    check_ready("fair3", 1'b1, 1'b0);
    tick();
    check_out("fair3", 1'b1, 32'h2, 16'hAAAA, 1'b0);
    check_ready("fair4", 1'b0, 1'b1);
    tick();
    check_out("fair4", 1'b1, 32'h4, 16'hBBBB, 1'b0);
    check("fair ConflictCount", 32'(ConflictCount), 32'd4);

    // Stall: no grants, priority stays with A, counter still runs.
    drive(1'b1, 5'd1, 16'hAAAA, 1'b1, 5'd2, 16'hBBBB, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check_ready("stall", 1'b0, 1'b0);
      tick();
      check_out("stall", 1'b0, 32'h0, 16'hBBBB, 1'b0);
    end
    check("stall ConflictCount", 32'(ConflictCount), 32'd7);
    drive(1'b1, 5'd1, 16'hAAAA, 1'b1, 5'd2, 16'hBBBB, 1'b0);
    check_ready("unstall", 1'b1, 1'b0);
    tick();
    check_out("unstall", 1'b1, 32'h2, 16'hAAAA, 1'b0);

    // Same address from both: B (priority) then A; A's value lands last.
    drive(1'b1, 5'd7, 16'h1111, 1'b1, 5'd7, 16'h2222, 1'b0);
    check_ready("same1", 1'b0, 1'b1);
    tick();
    check_out("same1", 1'b1, 32'h80, 16'h2222, 1'b0);
    check_ready("same2", 1'b1, 1'b0);
    tick();
    check_out("same2", 1'b1, 32'h80, 16'h1111, 1'b0);
    check("same ConflictCount", 32'(ConflictCount), 32'd10);

    // Protected write to register 0 from B.
    WriteProtect = 32'h0000_0001;
    drive(1'b0, 5'd0, 16'h0, 1'b1, 5'd0, 16'h5555, 1'b0);
    check_ready("prot", 1'b0, 1'b1);
    tick();
    check_out("prot", 1'b0, 32'h0, 16'h1111, 1'b1);
    drive(1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 16'h0, 1'b0);
    tick();
    check_out("prot idle", 1'b0, 32'h0, 16'h1111, 1'b0);
    WriteProtect = '0;

    // Reset in the cycle after a grant to A (priority now B).
    drive(1'b1, 5'd3, 16'h3333, 1'b0, 5'd0, 16'h0, 1'b0);
    tick();
    check_out("pre-rst", 1'b1, 32'h8, 16'h3333, 1'b0);
    ResetN = 1'b0;
    #1;
    check_out("mid-rst", 1'b0, 32'h0, 16'h0, 1'b0);
    check_ready("mid-rst", 1'b0, 1'b0);
    check("mid-rst ConflictCount", 32'(ConflictCount), 32'd0);
    @(negedge Clock);
    ResetN = 1'b1;
    drive(1'b1, 5'd6, 16'h6666, 1'b1, 5'd8, 16'h8888, 1'b0);
    check_ready("post-rst", 1'b1, 1'b0);
    tick();
    check_out("post-rst", 1'b1, 32'h40, 16'h6666, 1'b0);

    // Saturation of the conflict counter.
    apply_reset();
    drive(1'b1, 5'd1, 16'h1, 1'b1, 5'd2, 16'h2, 1'b1);
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 254) check("sat 254", 32'(ConflictCount), 32'd254);
      if (i == 255) check("sat 255", 32'(ConflictCount), 32'd255);
    end
    check("sat 300", 32'(ConflictCount), 32'd255);

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of registers; fixed at 32 for this release.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, register word width.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: Clock  input  1  rising-edge clock.
REQ-004 SHALL have ResetN  input  1  asynchronous active-low reset.
REQ-005 SHALL have AValid  input  1  requester A write request.
REQ-006 SHALL have AAddress  input  5  requester A register index, 0..31.
REQ-007 SHALL have AData  input  16  requester A write value.
REQ-008 SHALL have AReady  output  1  requester A request accepted this cycle.
REQ-009 SHALL have BValid, BAddress, BData, BReady  as REQ-005..008, for requester B.
REQ-010 SHALL have Stall  input  1  register file cannot take a write this cycle.
REQ-011 SHALL have WriteProtect  input  32 [32:1]  per-register write-protect mask.
REQ-012 SHALL have WriteEnable  output  1  registered write strobe to the register file.
REQ-013 SHALL have WriteAddressDecoded  output  32 [32:1]  registered one-hot write select.
REQ-014 SHALL have WriteValue  output  16 [16:1]  registered write data.
REQ-015 SHALL have ProtectError  output  1  one-cycle pulse: accepted write was dropped.
REQ-016 SHALL have ConflictCount  output  8  saturating count of cycles with both requesters valid.

Function
REQ-017 SHALL accept a request on handshake XValid=1 and XReady=1 at a rising Clock edge; Valid shall not depend on Ready.
REQ-018 SHALL hold AReady=BReady=0 whenever Stall=1.
REQ-019 SHALL, with Stall=0 and one requester valid, assert only that requester's Ready, combinationally in the same cycle.
REQ-020 SHALL, with Stall=0 and both valid, assert Ready only to the requester selected by the round-robin pointer Priority (0=A, 1=B).
REQ-021 SHALL set Priority to the non-granted requester after every accepted handshake; Priority unchanged in cycles with no handshake.
REQ-022 SHALL accept at most one request per cycle.
REQ-023 SHALL, one cycle after an accepted handshake to a non-protected register, drive WriteEnable=1, WriteAddressDecoded bit (Address+1) =1 with all others 0, and WriteValue=accepted data, for exactly one cycle.
REQ-024 SHALL treat a write as protected when WriteProtect[Address+1]=1, sampled at the handshake edge.
REQ-025 SHALL, for a protected write, still complete the handshake and advance Priority, but in the next cycle drive WriteEnable=0, WriteAddressDecoded=0, and ProtectError=1 for one cycle.
REQ-026 SHALL, in cycles with no accepted write pending, drive WriteEnable=0 and WriteAddressDecoded=0; WriteValue holds its last value.
REQ-027 SHALL increment ConflictCount on each clock edge where AValid=1 and BValid=1, regardless of Stall, saturating at 255 with no wrap.
REQ-028 SHALL process same-address requests from A and B in successive cycles in grant order; the later grant's value is the final register contents.
REQ-029 SHALL allow back-to-back accepted handshakes every cycle; sustained throughput one write per cycle with Stall=0.
REQ-030 SHALL not re-present or buffer a dropped (protected) write.

Reset
REQ-031 SHALL, while ResetN=0 and independent of Clock, force WriteEnable=0, WriteAddressDecoded=0, WriteValue=0, ProtectError=0, ConflictCount=0, Priority=0 (A).
REQ-032 SHALL hold AReady=BReady=0 while ResetN=0.
REQ-033 SHALL discard any write accepted in the cycle before reset assertion; it shall not appear on WriteEnable after reset release.
REQ-034 SHALL resume arbitration on the first rising Clock edge after ResetN deasserts, with A as first priority.

Verification
REQ-035 SHALL verify single write: AValid=1, AAddress=5, AData=16'h1234, Stall=0 -> AReady=1 same cycle; next cycle WriteEnable=1, WriteAddressDecoded[6]=1 only, WriteValue=16'h1234.
REQ-036 SHALL verify fairness: A and B valid for 4 cycles after reset -> grants A,B,A,B; ConflictCount=4.
REQ-037 SHALL verify stall: both valid, Stall=1 for 3 cycles -> no Ready, WriteEnable=0, Priority unchanged; Stall=0 -> A granted first.
REQ-038 SHALL verify protection: WriteProtect[1]=1, BValid=1, BAddress=0 -> BReady=1; next cycle ProtectError=1, WriteEnable=0, WriteAddressDecoded=0.
REQ-039 SHALL verify saturation: both valid for 300 cycles -> ConflictCount=255 and stays 255.
REQ-040 SHALL verify reset mid-operation: ResetN=0 in cycle after a grant -> WriteEnable=0 immediately, all outputs at reset values, A first priority after release.
